// File: rtl/bip_uart_pkg.sv
// Shared definitions for the BIP result -> UART path: frame FSM encoding and byte defaults.
package bip_uart_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEND = 2'd1,
        ST_WAIT = 2'd2,
        ST_DONE = 2'd3
    } tx_state_e;

    localparam int         DBIT_DEF   = 8;
    localparam logic [7:0] HEADER_DEF = 8'hA5;

endpackage

// File: rtl/rise_detect.sv
// Registered rising-edge detector; o_rise is combinational off the registered previous level.
module rise_detect (
    input  logic i_clk,
    input  logic i_reset,
    input  logic i_sig,
    output logic o_rise
);

    logic trig_q;

    always_ff @(posedge i_clk) begin
        if (!i_reset) trig_q <= 1'b0;
        else          trig_q <= i_sig;
    end

    assign o_rise = i_sig & ~trig_q;

endmodule

// File: rtl/acc_frame_tx.sv
// Packs a captured result word into [header] data bytes (LSB first) [xor checksum]
// and hands the bytes one at a time to uart_tx through its start/done handshake.
module acc_frame_tx
    import bip_uart_pkg::*;
#(
    parameter int              NBITS_D   = 16,
    parameter int              DBIT      = DBIT_DEF,
    parameter int              HEADER_EN = 1,
    parameter logic [DBIT-1:0] HEADER    = DBIT'(HEADER_DEF),
    parameter int              CHKSUM_EN = 1
) (
    input  logic               i_clk,
    input  logic               i_reset,
    input  logic               i_trigger,
    input  logic [NBITS_D-1:0] i_data,
    input  logic               i_tx_done,
    output logic               o_tx_start,
    output logic [DBIT-1:0]    o_tx_data,
    output logic               o_busy,
    output logic               o_frame_done,
    output logic               o_overrun
);

    localparam int NBYTES = (NBITS_D + DBIT - 1) / DBIT;
    localparam int WW     = NBYTES * DBIT;
    localparam int FLEN   = HEADER_EN + NBYTES + CHKSUM_EN;
    localparam int IW     = (FLEN > 1) ? $clog2(FLEN) : 1;
    localparam logic [IW-1:0] LAST = IW'(FLEN - 1);

    tx_state_e                    state_q, state_d;
    logic [IW-1:0]                idx_q;
    logic [NBYTES-1:0][DBIT-1:0]  word_q;
    logic                         overrun_q;
    logic                         rise;
    logic [DBIT-1:0]              chksum;
    logic [DBIT-1:0]              byte_sel;

    rise_detect u_rise (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .i_sig   (i_trigger),
        .o_rise  (rise)
    );

    always_comb begin
        chksum = '0;
        for (int b = 0; b < NBYTES; b++) chksum ^= word_q[b];
    end

    // Frame position -> byte; anything past the data bytes is the checksum slot.
    always_comb begin
        byte_sel = chksum;
        if (HEADER_EN != 0 && idx_q == '0) begin
            byte_sel = HEADER;
        end else begin
            for (int b = 0; b < NBYTES; b++)
                if (int'(idx_q) == b + HEADER_EN) byte_sel = word_q[b];
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            state_q   <= ST_IDLE;
            idx_q     <= '0;
            word_q    <= '0;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            overrun_q <= rise && (state_q != ST_IDLE);
            case (state_q)
                ST_IDLE: if (rise) begin
                    word_q <= WW'(i_data);
                    idx_q  <= '0;
                end
                ST_WAIT: if (i_tx_done && idx_q != LAST) idx_q <= idx_q + IW'(1);
                default: ;
            endcase
        end
    end

    always_comb begin
        state_d      = state_q;
        o_tx_start   = 1'b0;
        o_busy       = 1'b0;
        o_frame_done = 1'b0;
        o_tx_data    = '0;
        case (state_q)
            ST_IDLE: if (rise) state_d = ST_SEND;
            ST_SEND: begin
                o_tx_start = 1'b1;
                o_busy     = 1'b1;
                o_tx_data  = byte_sel;
                state_d    = ST_WAIT;
            end
            ST_WAIT: begin
                o_busy    = 1'b1;
                o_tx_data = byte_sel;
                if (i_tx_done) state_d = (idx_q == LAST) ? ST_DONE : ST_SEND;
            end
            ST_DONE: begin
                o_frame_done = 1'b1;
                state_d      = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign o_overrun = overrun_q;

endmodule

// File: tb/tb_acc_frame_tx.sv
// Directed bench for acc_frame_tx: three parameterisations, each with a uart_tx model
// that returns i_tx_done ten cycles after every o_tx_start.
module tb_acc_frame_tx;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    // a: defaults, b: no header/checksum, c: 20-bit word
    logic        trig_a = 0, trig_b = 0, trig_c = 0;
    logic [15:0] data_a = '0, data_b = '0;
    logic [19:0] data_c = '0;
    logic        done_a, done_b, done_c;
    logic        spur_a = 0;
    logic        start_a, start_b, start_c;
    logic [7:0]  txd_a, txd_b, txd_c;
    logic        busy_a, busy_b, busy_c;
    logic        fd_a, fd_b, fd_c;
    logic        ovr_a, ovr_b, ovr_c;

    acc_frame_tx u_a (
        .i_clk(clk), .i_reset(rst), .i_trigger(trig_a), .i_data(data_a), .i_tx_done(done_a),
        .o_tx_start(start_a), .o_tx_data(txd_a), .o_busy(busy_a), .o_frame_done(fd_a), .o_overrun(ovr_a)
    );

    acc_frame_tx #(.HEADER_EN(0), .CHKSUM_EN(0)) u_b (
        .i_clk(clk), .i_reset(rst), .i_trigger(trig_b), .i_data(data_b), .i_tx_done(done_b),
        .o_tx_start(start_b), .o_tx_data(txd_b), .o_busy(busy_b), .o_frame_done(fd_b), .o_overrun(ovr_b)
    );

    acc_frame_tx #(.NBITS_D(20)) u_c (
        .i_clk(clk), .i_reset(rst), .i_trigger(trig_c), .i_data(data_c), .i_tx_done(done_c),
        .o_tx_start(start_c), .o_tx_data(txd_c), .o_busy(busy_c), .o_frame_done(fd_c), .o_overrun(ovr_c)
    );

    // uart_tx models: load 11 on start so done lands exactly 10 cycles after the start cycle
    int cnt_a = 0, cnt_b = 0, cnt_c = 0;
    always @(posedge clk) begin
        if (!rst) begin
            cnt_a <= 0; cnt_b <= 0; cnt_c <= 0;
        end else begin
            if (start_a) cnt_a <= 11; else if (cnt_a != 0) cnt_a <= cnt_a - 1;
            if (start_b) cnt_b <= 11; else if (cnt_b != 0) cnt_b <= cnt_b - 1;
            if (start_c) cnt_c <= 11; else if (cnt_c != 0) cnt_c <= cnt_c - 1;
        end
    end
    assign done_a = (cnt_a == 1) | spur_a;
    assign done_b = (cnt_b == 1);
    assign done_c = (cnt_c == 1);

    logic [7:0] q_a[$], q_b[$], q_c[$];
    int fdc_a = 0, fdc_b = 0, fdc_c = 0, ovc_a = 0;
    always @(negedge clk) begin
        if (start_a) q_a.push_back(txd_a);
        if (start_b) q_b.push_back(txd_b);
        if (start_c) q_c.push_back(txd_c);
        if (fd_a) fdc_a++;
        if (fd_b) fdc_b++;
        if (fd_c) fdc_c++;
        if (ovr_a) ovc_a++;
    end

    task automatic wait_fd(input int which, input int target, output bit ok);
        ok = 0;
        for (int i = 0; i < 600; i++) begin
            @(negedge clk);
            if ((which == 0 && fdc_a >= target) || (which == 1 && fdc_b >= target) ||
                (which == 2 && fdc_c >= target)) begin
                ok = 1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst = 0;
        repeat (3) @(negedge clk);
        n_cmp++;
        if ({start_a, busy_a, fd_a, ovr_a, txd_a} !== 12'h0) begin
            n_err++; $display("FAIL reset_a: got %h want 0", {start_a, busy_a, fd_a, ovr_a, txd_a});
        end
        n_cmp++;
        if ({start_b, busy_b, fd_b, ovr_b, txd_b} !== 12'h0) begin
            n_err++; $display("FAIL reset_b: got %h want 0", {start_b, busy_b, fd_b, ovr_b, txd_b});
        end
        n_cmp++;
        if ({start_c, busy_c, fd_c, ovr_c, txd_c} !== 12'h0) begin
            n_err++; $display("FAIL reset_c: got %h want 0", {start_c, busy_c, fd_c, ovr_c, txd_c});
        end
        rst = 1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_basic();
        logic [7:0] exp[4] = '{8'hA5, 8'h34, 8'h12, 8'h26};
        bit ok;
        q_a.delete(); fdc_a = 0;
        data_a = 16'h1234; trig_a = 1;
        @(posedge clk); @(negedge clk);
        n_cmp++;
        if ({start_a, busy_a, txd_a} !== {1'b1, 1'b1, 8'hA5}) begin
            n_err++; $display("FAIL basic_first_start: got %b/%b/%h want 1/1/a5", start_a, busy_a, txd_a);
        end
        wait_fd(0, 1, ok);
        n_cmp++;
        if (!ok) begin n_err++; $display("FAIL basic_timeout: frame_done not seen"); end
        n_cmp++;
        if (q_a.size() != 4) begin n_err++; $display("FAIL basic_len: got %0d want 4", q_a.size()); end
        for (int i = 0; i < 4; i++) begin
            n_cmp++;
            if (q_a[i] !== exp[i]) begin
                n_err++; $display("FAIL basic_byte%0d: got %h want %h", i, q_a[i], exp[i]);
            end
        end
        repeat (3) @(negedge clk);
        n_cmp++;
        if (busy_a !== 1'b0 || fdc_a != 1) begin
            n_err++; $display("FAIL basic_end: busy %b frames %0d want 0/1", busy_a, fdc_a);
        end
        trig_a = 0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_no_header();
        bit ok;
        q_b.delete(); fdc_b = 0;
        data_b = 16'h1234; trig_b = 1;
        @(posedge clk); @(negedge clk);
        n_cmp++;
        if ({start_b, txd_b} !== {1'b1, 8'h34}) begin
            n_err++; $display("FAIL nohdr_first_start: got %b/%h want 1/34", start_b, txd_b);
        end
        wait_fd(1, 1, ok);
        repeat (20) @(negedge clk);
        n_cmp++;
        if (!ok || q_b.size() != 2) begin
            n_err++; $display("FAIL nohdr_len: ok %0d got %0d bytes want 2", ok, q_b.size());
        end
        n_cmp++;
        if (q_b.size() == 2 && {q_b[0], q_b[1]} !== 16'h3412) begin
            n_err++; $display("FAIL nohdr_bytes: got %h %h want 34 12", q_b[0], q_b[1]);
        end
        trig_b = 0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_wide();
        logic [7:0] exp[5] = '{8'hA5, 8'hDE, 8'hBC, 8'h0A, 8'h68};
        bit ok;
        q_c.delete(); fdc_c = 0;
        data_c = 20'hABCDE; trig_c = 1;
        wait_fd(2, 1, ok);
        n_cmp++;
        if (!ok || q_c.size() != 5) begin
            n_err++; $display("FAIL wide_len: ok %0d got %0d bytes want 5", ok, q_c.size());
        end
        for (int i = 0; i < 5; i++) begin
            n_cmp++;
            if (q_c[i] !== exp[i]) begin
                n_err++; $display("FAIL wide_byte%0d: got %h want %h", i, q_c[i], exp[i]);
            end
        end
        trig_c = 0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_held_and_overrun();
        logic [7:0] exp[4] = '{8'hA5, 8'h34, 8'h12, 8'h26};
        bit ok;
        q_a.delete(); fdc_a = 0; ovc_a = 0;
        data_a = 16'h1234; trig_a = 1;
        repeat (200) @(negedge clk);
        n_cmp++;
        if (fdc_a != 1 || q_a.size() != 4) begin
            n_err++; $display("FAIL held_single: frames %0d bytes %0d want 1/4", fdc_a, q_a.size());
        end
        trig_a = 0;
        repeat (2) @(negedge clk);
        q_a.delete(); fdc_a = 0; ovc_a = 0;
        trig_a = 1;
        repeat (15) @(negedge clk);
        trig_a = 0;
        @(negedge clk);
        trig_a = 1;
        wait_fd(0, 1, ok);
        repeat (100) @(negedge clk);
        n_cmp++;
        if (ovc_a != 1) begin n_err++; $display("FAIL overrun_pulse: got %0d pulses want 1", ovc_a); end
        n_cmp++;
        if (!ok || fdc_a != 1 || q_a.size() != 4) begin
            n_err++; $display("FAIL overrun_frames: frames %0d bytes %0d want 1/4", fdc_a, q_a.size());
        end
        for (int i = 0; i < 4; i++) begin
            n_cmp++;
            if (q_a[i] !== exp[i]) begin
                n_err++; $display("FAIL overrun_byte%0d: got %h want %h", i, q_a[i], exp[i]);
            end
        end
        trig_a = 0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_reset_mid();
        logic [7:0] exp[4] = '{8'hA5, 8'h34, 8'h12, 8'h26};
        int  dones = 0;
        bit  ok = 0;
        q_a.delete(); fdc_a = 0;
        data_a = 16'h1234; trig_a = 1;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (done_a) dones++;
            if (dones == 2) begin ok = 1; break; end
        end
        n_cmp++;
        if (!ok) begin n_err++; $display("FAIL rstmid_timeout: second tx_done not seen"); end
        rst = 0; trig_a = 0;
        @(posedge clk); @(negedge clk);
        n_cmp++;
        if ({start_a, busy_a, fd_a, ovr_a, txd_a} !== 12'h0) begin
            n_err++; $display("FAIL rstmid_outputs: got %h want 0", {start_a, busy_a, fd_a, ovr_a, txd_a});
        end
        rst = 1;
        repeat (20) @(negedge clk);
        n_cmp++;
        if (fdc_a != 0 || q_a.size() != 2) begin
            n_err++; $display("FAIL rstmid_abort: frames %0d bytes %0d want 0/2", fdc_a, q_a.size());
        end
        q_a.delete();
        trig_a = 1;
        wait_fd(0, 1, ok);
        n_cmp++;
        if (!ok || q_a.size() != 4) begin
            n_err++; $display("FAIL rstmid_refr_len: ok %0d bytes %0d want 4", ok, q_a.size());
        end
        for (int i = 0; i < 4; i++) begin
            n_cmp++;
            if (q_a[i] !== exp[i]) begin
                n_err++; $display("FAIL rstmid_byte%0d: got %h want %h", i, q_a[i], exp[i]);
            end
        end
        trig_a = 0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_spurious();
        logic [7:0] exp[4] = '{8'hA5, 8'h34, 8'h12, 8'h26};
        bit ok;
        q_a.delete(); fdc_a = 0;
        spur_a = 1;
        @(negedge clk);
        spur_a = 0;
        repeat (5) @(negedge clk);
        n_cmp++;
        if (q_a.size() != 0 || busy_a !== 1'b0) begin
            n_err++; $display("FAIL spur_idle: starts %0d busy %b want 0/0", q_a.size(), busy_a);
        end
        data_a = 16'h1234; trig_a = 1;
        repeat (15) @(negedge clk);
        data_a = 16'hFFFF;
        wait_fd(0, 1, ok);
        n_cmp++;
        if (!ok || q_a.size() != 4) begin
            n_err++; $display("FAIL spur_len: ok %0d bytes %0d want 4", ok, q_a.size());
        end
        for (int i = 0; i < 4; i++) begin
            n_cmp++;
            if (q_a[i] !== exp[i]) begin
                n_err++; $display("FAIL datachg_byte%0d: got %h want %h", i, q_a[i], exp[i]);
            end
        end
        trig_a = 0;
        repeat (2) @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_no_header();
        test_wide();
        test_held_and_overrun();
        test_reset_mid();
        test_spurious();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
